sha_schedule: RTL

SHA_SCHEDULE -- requirements
Module: sha_schedule

---
 rtl/sha_pkg.sv | 58 +++++
 rtl/sha_k_rom.sv | 11 +
 rtl/sha_schedule.sv | 113 +++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// SHA-2 shared definitions: hash modes, schedule FSM states, the SHA-256
// round-constant table and the message-schedule sigma functions.
package sha;

    typedef enum logic [2:0] {
        SHA1   = 3'd0,
        SHA224 = 3'd1,
        SHA256 = 3'd2,
        SHA384 = 3'd3,
        SHA512 = 3'd4
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int WIN_WORDS  = 16;
    localparam int NUM_ROUNDS = 64;

    // First 32 bits of the fractional parts of the cube roots of the first 64 primes.
    localparam logic [31:0] K256 [NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Only the 32-bit-word SHA-2 variants share this schedule.
    function automatic logic is_sha256_family(input mode_t m);
        return (m == SHA224) || (m == SHA256);
    endfunction

endpackage

// File: rtl/sha_k_rom.sv
// Combinational lookup of the SHA-256 round constant for a round index.
import sha::*;

module sha_k_rom (
    input  logic [5:0]  idx,
    output logic [31:0] k
);

    assign k = K256[idx];

endmodule

// File: rtl/sha_schedule.sv
// SHA-224/256 message schedule: holds a sliding 16-word window, presents
// W[t]/K[t] to the compression mainloop one round per handshake and
// expands the next word as the window shifts.
import sha::*;

module sha_schedule (
    input  logic         clk,
    input  logic         rstn,
    input  mode_t        mode,
    input  logic         start,
    input  logic [511:0] block,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  w,
    output logic [31:0]  k,
    output logic [5:0]   round,
    output logic         last,
    output logic         done
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] win_reg [WIN_WORDS];
    logic [5:0]  cnt_reg;
    mode_t       mode_reg;
    logic        done_reg;

    logic [31:0] block_words [WIN_WORDS];
    logic [31:0] new_word;
    logic [31:0] k_rom;
    logic        accept;
    logic        run;
    logic        fire;
    logic        final_round;

    // Big-endian word split: W0 is the most significant word of the block.
    genvar gi;
    generate
        for (gi = 0; gi < WIN_WORDS; gi++) begin : g_block_words
            assign block_words[gi] = block[511 - 32*gi -: 32];
        end
    endgenerate

    sha_k_rom u_k_rom (
        .idx (cnt_reg),
        .k   (k_rom)
    );

    assign accept      = (state_reg == ST_IDLE) && start && is_sha256_family(mode);
    assign run         = (state_reg == ST_RUN) && is_sha256_family(mode_reg);
    assign fire        = run && out_ready;
    assign final_round = (cnt_reg == 6'd63);

    // Expansion runs every cycle; words produced past round 47 are never consumed.
    assign new_word = sigma1(win_reg[14]) + win_reg[9] + sigma0(win_reg[1]) + win_reg[0];

    // State register and the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= fire && final_round;
        end
    end

    // Window load on accepted start, shift/expand and count on each handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                win_reg[i] <= '0;
            end
            cnt_reg  <= '0;
            mode_reg <= SHA1;
        end else if (accept) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
                win_reg[i] <= block_words[i];
            end
            cnt_reg  <= '0;
            mode_reg <= mode;
        end else if (fire) begin
            for (int i = 0; i < WIN_WORDS - 1; i++) begin
                win_reg[i] <= win_reg[i + 1];
            end
            win_reg[WIN_WORDS - 1] <= new_word;
            cnt_reg                <= cnt_reg + 6'd1;
        end
    end

    // Next state: start a block from IDLE, finish after the round-63 handshake.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)              state_next = ST_RUN;
            ST_RUN:  if (fire && final_round) state_next = ST_IDLE;
            default:                          state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced to zero outside RUN so the mainloop sees a clean idle bus.
    always_comb begin
        out_valid = run;
        busy      = run;
        last      = run && final_round;
        w         = run ? win_reg[0] : 32'h0;
        k         = run ? k_rom : 32'h0;
        round     = run ? cnt_reg : 6'd0;
        done      = done_reg;
    end

endmodule
